// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an 8N1 serializer for the debug UART link.
// Bytes pushed by the debug unit are queued, then sent LSB first with one start
// and one stop bit. A one-cycle dataSent pulse marks the final clock of each stop bit.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_ADDR_W  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             dataIn,
    input  logic                   writeFifoFlag,
    input  logic                   notStartUartTrans,
    output logic                   tx,
    output logic                   dataSent,
    output logic                   fifoFull,
    output logic                   fifoEmpty,
    output logic [FIFO_ADDR_W:0]   fifoCount,
    output logic                   busy,
    output logic                   overflow
);

    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]     BAUD_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    // dataSent is registered, so it is raised one clock ahead of the bit-period end
    localparam logic [CNT_W-1:0]     BAUD_PRELAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [FIFO_ADDR_W:0] FULL_COUNT   = (FIFO_ADDR_W + 1)'(DEPTH);
    localparam logic [FIFO_ADDR_W:0] COUNT_ONE    = (FIFO_ADDR_W + 1)'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]             fifoMem_r [DEPTH];
    logic [FIFO_ADDR_W-1:0] wrPtr_r;
    logic [FIFO_ADDR_W-1:0] rdPtr_r;
    logic [FIFO_ADDR_W:0]   count_r;
    logic                   full_r;
    logic                   empty_r;
    logic                   overflow_r;

    logic [1:0]             state_r;
    logic [CNT_W-1:0]       baudCnt_r;
    logic [2:0]             bitIdx_r;
    logic [7:0]             shift_r;
    logic                   tx_r;
    logic                   dataSent_r;
    logic                   busy_r;

    logic                   push_s;
    logic                   pop_s;
    logic                   baudEnd_s;
    logic [FIFO_ADDR_W:0]   nextCount_s;

    // Push/pop qualification and the post-edge FIFO occupancy
    always_comb begin
        push_s      = writeFifoFlag && !full_r;
        pop_s       = (state_r == ST_IDLE) && !empty_r && !notStartUartTrans;
        baudEnd_s   = (baudCnt_r == BAUD_LAST);
        nextCount_s = count_r;
        if (push_s && !pop_s) begin
            nextCount_s = count_r + COUNT_ONE;
        end else if (pop_s && !push_s) begin
            nextCount_s = count_r - COUNT_ONE;
        end else begin
            nextCount_s = count_r;
        end
    end

    // FIFO storage; contents need no reset because pointers gate every read
    always_ff @(posedge clock) begin
        if (push_s && !reset) begin
            fifoMem_r[wrPtr_r] <= dataIn;
        end
    end

    // FIFO pointers, occupancy, flags and the sticky overflow indicator
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_r    <= {FIFO_ADDR_W{1'b0}};
            rdPtr_r    <= {FIFO_ADDR_W{1'b0}};
            count_r    <= {(FIFO_ADDR_W + 1){1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wrPtr_r <= wrPtr_r + 1'b1;
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + 1'b1;
            end
            if (writeFifoFlag && full_r) begin
                overflow_r <= 1'b1;
            end
            count_r <= nextCount_s;
            full_r  <= (nextCount_s == FULL_COUNT);
            empty_r <= (nextCount_s == {(FIFO_ADDR_W + 1){1'b0}});
        end
    end

    // Frame sequencer: start bit, eight data bits LSB first, stop bit
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            baudCnt_r  <= {CNT_W{1'b0}};
            bitIdx_r   <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            dataSent_r <= 1'b0;
        end else begin
            dataSent_r <= (state_r == ST_STOP) && (baudCnt_r == BAUD_PRELAST);
            if (state_r == ST_IDLE) begin
                baudCnt_r <= {CNT_W{1'b0}};
            end else if (baudEnd_s) begin
                baudCnt_r <= {CNT_W{1'b0}};
            end else begin
                baudCnt_r <= baudCnt_r + 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_r  <= fifoMem_r[rdPtr_r];
                        bitIdx_r <= 3'd0;
                        tx_r     <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_START;
                    end else begin
                        tx_r     <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baudEnd_s) begin
                        tx_r     <= shift_r[0];
                        bitIdx_r <= 3'd0;
                        state_r  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baudEnd_s) begin
                        if (bitIdx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            bitIdx_r <= bitIdx_r + 3'd1;
                            shift_r  <= {1'b0, shift_r[7:1]};
                            tx_r     <= shift_r[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (baudEnd_s) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx        = tx_r;
    assign dataSent  = dataSent_r;
    assign busy      = busy_r;
    assign fifoFull  = full_r;
    assign fifoEmpty = empty_r;
    assign fifoCount = count_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a frame-time reference model (byte queue plus a
// cycle counter within the current frame) predicts every output on every clock.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int FRAME = 10 * CPB;

    logic          clock;
    logic          reset;
    logic [7:0]    dataIn;
    logic          writeFifoFlag;
    logic          notStartUartTrans;
    logic          tx;
    logic          dataSent;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [AW:0]   fifoCount;
    logic          busy;
    logic          overflow;

    int checks;
    int errors;

    // reference model state
    logic [7:0] mQueue[$];
    bit         mActive;
    int         mT;
    logic [7:0] mByte;
    bit         mOvf;
    int         mPulses;
    int         obsPulses;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_W(AW)) dut (
        .clock(clock),
        .reset(reset),
        .dataIn(dataIn),
        .writeFifoFlag(writeFifoFlag),
        .notStartUartTrans(notStartUartTrans),
        .tx(tx),
        .dataSent(dataSent),
        .fifoFull(fifoFull),
        .fifoEmpty(fifoEmpty),
        .fifoCount(fifoCount),
        .busy(busy),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line level for the current frame position: bit slot = elapsed clocks / CPB
    function automatic logic expTx();
        int slot;
        if (!mActive) return 1'b1;
        slot = mT / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return mByte[slot - 1];
        return 1'b1;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT saw
    task automatic modelStep();
        bit wasFull;
        bit startNow;
        if (reset) begin
            mQueue.delete();
            mActive = 1'b0;
            mT      = 0;
            mOvf    = 1'b0;
        end else begin
            wasFull  = (mQueue.size() == DEPTH);
            startNow = !mActive && (mQueue.size() != 0) && !notStartUartTrans;
            if (mActive) begin
                if (mT == FRAME - 1) mActive = 1'b0;
                else mT++;
            end
            if (startNow) begin
                mByte   = mQueue.pop_front();
                mActive = 1'b1;
                mT      = 0;
            end
            if (writeFifoFlag) begin
                if (!wasFull) mQueue.push_back(dataIn);
                else mOvf = 1'b1;
            end
        end
        if (mActive && mT == FRAME - 1) mPulses++;
    endtask

    task automatic compareAll();
        int n;
        n = mQueue.size();
        checkVal("tx",        32'(tx),        32'(expTx()));
        checkVal("dataSent",  32'(dataSent),  32'(mActive && mT == FRAME - 1));
        checkVal("busy",      32'(busy),      32'(mActive));
        checkVal("fifoCount", 32'(fifoCount), 32'(n));
        checkVal("fifoFull",  32'(fifoFull),  32'(n == DEPTH));
        checkVal("fifoEmpty", 32'(fifoEmpty), 32'(n == 0));
        checkVal("overflow",  32'(overflow),  32'(mOvf));
        if (dataSent === 1'b1) obsPulses++;
    endtask

    task automatic doCycle(input logic wr, input logic [7:0] d, input logic inh, input logic rst);
        writeFifoFlag     = wr;
        dataIn            = d;
        notStartUartTrans = inh;
        reset             = rst;
        @(posedge clock);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic idle(input int n, input logic inh);
        for (int i = 0; i < n; i++) doCycle(1'b0, 8'h00, inh, 1'b0);
    endtask

    initial begin
        int wrRate;
        logic inh;
        checks    = 0;
        errors    = 0;
        mActive   = 1'b0;
        mT        = 0;
        mOvf      = 1'b0;
        mByte     = 8'h00;
        mPulses   = 0;
        obsPulses = 0;

        // reset state
        doCycle(1'b0, 8'h00, 1'b0, 1'b1);
        doCycle(1'b0, 8'h00, 1'b0, 1'b1);

        // single byte 0xA5
        doCycle(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(50, 1'b0);

        // fill with inhibit, 17th write overflows, then drain 16 frames
        for (int i = 0; i < 17; i++) doCycle(1'b1, 8'(i), 1'b1, 1'b0);
        idle(5, 1'b1);
        idle(16 * (FRAME + 1) + 10, 1'b0);

        // inhibit asserted during DATA of 0x3C with 0x5A queued
        doCycle(1'b1, 8'h3C, 1'b0, 1'b0);
        doCycle(1'b1, 8'h5A, 1'b0, 1'b0);
        idle(12, 1'b0);
        idle(70, 1'b1);
        idle(FRAME + 10, 1'b0);

        // simultaneous push and pop with one entry held
        doCycle(1'b1, 8'h11, 1'b1, 1'b0);
        doCycle(1'b1, 8'h7E, 1'b0, 1'b0);
        idle(2 * (FRAME + 1) + 5, 1'b0);

        // reset during data bit 3 with bytes queued, then 0x55
        doCycle(1'b1, 8'h81, 1'b0, 1'b0);
        doCycle(1'b1, 8'h42, 1'b0, 1'b0);
        doCycle(1'b1, 8'h24, 1'b0, 1'b0);
        doCycle(1'b1, 8'h18, 1'b0, 1'b0);
        idle(14, 1'b0);
        doCycle(1'b0, 8'h00, 1'b0, 1'b1);
        doCycle(1'b1, 8'h55, 1'b0, 1'b0);
        idle(FRAME + 5, 1'b0);

        // data extremes back to back
        doCycle(1'b1, 8'h00, 1'b0, 1'b0);
        doCycle(1'b1, 8'hFF, 1'b0, 1'b0);
        idle(2 * (FRAME + 1) + 5, 1'b0);

        // randomized traffic with varying write rate, inhibit toggles and rare resets
        inh    = 1'b0;
        wrRate = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) wrRate = $urandom_range(2, 60);
            if ($urandom_range(0, 29) == 0) inh = ~inh;
            doCycle(($urandom_range(0, wrRate - 1) == 0), 8'($urandom), inh,
                    ($urandom_range(0, 799) == 0));
        end
        idle(DEPTH * (FRAME + 1) + 10, 1'b0);

        checkVal("pulseTotal", 32'(obsPulses), 32'(mPulses));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
